// File: rtl/rgb_pwm_gen_pkg.sv
// Shared constants and types for the RGB PWM output stage.
package rgb_pwm_gen_pkg;

  // Duty word width; also the period counter width.
  localparam int unsigned DUTY_W = 8;

  // Number of LED channels driven by the block.
  localparam int unsigned NUM_CH = 3;

  // Channel select encoding on in_ch.
  localparam logic [1:0] CH_R    = 2'd0;
  localparam logic [1:0] CH_G    = 2'd1;
  localparam logic [1:0] CH_B    = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, free-running period counter, commit strobe
// and registered period_start pulse.
module pwm_timebase
  import rgb_pwm_gen_pkg::*;
#(
  parameter int unsigned PRESC   = 1,
  parameter duty_t       CNT_MAX = 8'hFF
) (
  input  logic  clk,
  input  logic  rst,
  output duty_t cnt,
  output logic  commit,
  output logic  period_start
);

  localparam logic [15:0] PrescLast = 16'(PRESC - 1);

  logic [15:0] presc_q, presc_d;
  duty_t       cnt_q, cnt_d;
  logic        tick;
  logic        period_start_q;

  // Next-state for prescaler and period counter; commit marks the last step of a period.
  always_comb begin
    tick    = (presc_q == PrescLast);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    commit  = tick & (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Timebase state; period_start is high in the cycle the counter has just wrapped to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= 16'd0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= commit;
    end
  end

  assign cnt          = cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM output stage. Duty words land in per-channel shadow
// registers and are committed to the active compare registers only at the
// period boundary, so a period never mixes old and new duty.
module rgb_pwm_gen
  import rgb_pwm_gen_pkg::*;
#(
  parameter int unsigned PRESC   = 1,
  parameter duty_t       CNT_MAX = 8'hFF,
  parameter logic        INVERT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_ch,
  input  duty_t       in_duty,
  output logic [2:0]  pwm,
  output logic        period_start
);

  duty_t       cnt;
  logic        commit;
  logic [2:0]  pending;
  logic [3:0]  pending_ext;
  logic        accept;

  pwm_timebase #(
    .PRESC   (PRESC),
    .CNT_MAX (CNT_MAX)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .cnt          (cnt),
    .commit       (commit),
    .period_start (period_start)
  );

  // Channel 3 maps to a permanently clear pending bit so it is always ready.
  assign pending_ext = {1'b0, pending};

  // Handshake: a pending channel stalls until the commit cycle frees it.
  always_comb begin
    in_ready = (in_ch == CH_NONE) | ~pending_ext[in_ch] | commit;
    accept   = in_valid & in_ready & (in_ch != CH_NONE);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [1:0] ChIdx = 2'(i);

    duty_t shadow_q, shadow_d;
    duty_t active_q, active_d;
    logic  pend_q, pend_d;
    logic  pwm_q, pwm_d;
    logic  wr;

    assign wr = accept & (in_ch == ChIdx);

    // Per-channel next state; a write in the commit cycle stays pending for the next period.
    always_comb begin
      shadow_d = wr ? in_duty : shadow_q;
      active_d = (commit & pend_q) ? shadow_q : active_q;
      if (wr) begin
        pend_d = 1'b1;
      end else if (commit) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
      pwm_d = INVERT ^ (cnt < active_q);
    end

    // Per-channel registers; reset drops any pending word and forces the LED off.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
        pend_q   <= 1'b0;
        pwm_q    <= INVERT;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        pend_q   <= pend_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pending[i] = pend_q;
    assign pwm[i]     = pwm_q;
  end

endmodule
